ether_rx_ctrl: RTL
==================

Name: ether_rx_ctrl

Overview:
- Sequences the receive datapath output (32-bit words from the aggregate stage) into single-outstanding bus transactions.
- Each received word is decoded into a read or write request and issued on the register bus.
- Read responses are handed to the transmit path; transmit is only started when that path is idle.
- Sits between the RMII receive chain (ether -> bitorder -> firewall -> aggregate) and the bus/transmit side.

Parameters:
- ADDR_WIDTH, 15, bus address width; taken from axiid[30:16].
- DATA_WIDTH, 16, bus data width; taken from axiid[15:0].
- RESP_TIMEOUT, 64, cycles to wait for a read response before aborting; minimum 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- axiiv  in  1  received word valid; single-cycle pulse from the aggregate stage.
- axiid  in  32  received word: [31]=rw (1 = write), [30:16]=addr, [15:0]=data.
- addr_o  out  ADDR_WIDTH  bus address, registered.
- data_o  out  DATA_WIDTH  bus write data, registered.
- rw_o  out  1  bus direction (1 = write), registered.
- valid_o  out  1  bus request strobe; one-cycle pulse.
- resp_valid_i  in  1  read response valid.
- resp_data_i  in  DATA_WIDTH  read response data.
- tx_start_o  out  1  transmit start; one-cycle pulse.
- tx_data_o  out  DATA_WIDTH  data to transmit; held stable from the tx_start_o pulse until the next read completes.
- tx_busy_i  in  1  transmit path busy.
- busy_o  out  1  high whenever state != IDLE.
- timeout_o  out  1  one-cycle pulse when a read times out.

Behaviour:
- Reset: state=IDLE; addr_o, data_o, rw_o, valid_o, tx_start_o, tx_data_o, busy_o, timeout_o all 0; timeout counter 0.
- Reset mid-operation aborts any transaction with no trailing pulses; the next cycle is IDLE.
- IDLE:
  - axiiv=1 at a clock edge with state==IDLE: latch rw/addr/data into rw_o/addr_o/data_o; go to ISSUE.
- ISSUE:
  - valid_o=1 for exactly this one cycle, so latency is axiiv at cycle N -> valid_o at cycle N+1.
  - rw=1 (write): go to IDLE.
  - rw=0 (read): clear the counter; go to WAIT_RESP.
- WAIT_RESP:
  - Counter increments each cycle.
  - resp_valid_i=1: latch resp_data_i into tx_data_o; go to TX_REQ.
  - Otherwise, once the counter reaches RESP_TIMEOUT-1: pulse timeout_o for one cycle; go to IDLE.
  - resp_valid_i and timeout in the same cycle: the response wins and timeout_o is not pulsed.
- TX_REQ:
  - Stay while tx_busy_i=1.
  - First cycle with tx_busy_i=0: tx_start_o=1 for one cycle; go to IDLE.
- Dropped inputs:
  - axiiv=1 while state != IDLE is dropped; the in-flight transaction is unaffected.
  - This includes the cycle in which the FSM is returning to IDLE, since acceptance is sampled on the current state only.
- Ignored inputs: resp_valid_i outside WAIT_RESP has no effect.
- Output holding: addr_o, data_o, rw_o hold their last value between transactions; they are only meaningful when valid_o=1.
- Counter width: $clog2(RESP_TIMEOUT)+1; the counter never wraps.

Optional Feature:
- Macro: ETHER_RX_CTRL_DROP_COUNT_EN.
- Defined:
  - Adds output drop_count_o[15:0]: count of dropped axiiv pulses.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
  - Increments by exactly 1 per dropped pulse.
  - Accepted words never increment it.
- Undefined: port and counter absent; drop behaviour is otherwise identical.

Decomposition:
- Shared package ether_pkg holds:
  - state enum (IDLE, ISSUE, WAIT_RESP, TX_REQ);
  - field positions RW_BIT=31, ADDR_MSB=30, ADDR_LSB=16, DATA_MSB=15, DATA_LSB=0;
  - default widths.
- One sub-module: rx_word_decode, a registered field split of axiid into rw/addr/data under a load enable.
- FSM and counters stay in ether_rx_ctrl.

Test Plan:
- Write: axiiv with axiid=32'h8012_BEEF -> next cycle valid_o=1, rw_o=1, addr_o=15'h0012, data_o=16'hBEEF; FSM returns to IDLE; tx_start_o never pulses.
- Read with response: axiid=32'h0034_0000, resp_valid_i with 16'h1234 three cycles after valid_o, tx_busy_i=0 -> tx_data_o=16'h1234 and tx_start_o pulses once on the following cycle.
- Timeout: read, with resp_valid_i held low -> timeout_o pulses exactly RESP_TIMEOUT cycles after valid_o; busy_o falls the same cycle; no tx_start_o.
- Backpressure: read response while tx_busy_i=1 for 10 cycles -> tx_start_o withheld, then pulses the cycle tx_busy_i falls; a second axiiv sent during the wait is dropped (drop_count_o=1 if enabled).
- Reset mid-WAIT_RESP: assert rst for one cycle -> all outputs 0, no timeout_o afterwards; a following write axiid=32'h8001_0001 is issued normally.
- Simultaneous events: resp_valid_i on the final timeout cycle -> tx_start_o pulses, timeout_o stays 0.

Source files
------------

// File: rtl/ether_pkg.sv
// Shared definitions for the Ethernet receive controller: word field positions,
// default widths and FSM state encodings.
package ether_pkg;

  localparam int RW_BIT   = 31;
  localparam int ADDR_MSB = 30;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  localparam int DEF_ADDR_WIDTH   = ADDR_MSB - ADDR_LSB + 1;
  localparam int DEF_DATA_WIDTH   = DATA_MSB - DATA_LSB + 1;
  localparam int DEF_RESP_TIMEOUT = 64;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;
  localparam logic [1:0] TX_REQ    = 2'd3;

endpackage

// File: rtl/rx_word_decode.sv
// Registered field split of a received 32-bit word into rw/addr/data,
// updated only when load_i is asserted and otherwise holding its value.
module rx_word_decode
  import ether_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [31:0]           word_i,
  output logic                  rw_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    rw_d   = rw_q;
    addr_d = addr_q;
    data_d = data_q;
    if (load_i) begin
      rw_d   = word_i[RW_BIT];
      addr_d = word_i[ADDR_LSB +: ADDR_WIDTH];
      data_d = word_i[DATA_LSB +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      rw_q   <= rw_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign rw_o   = rw_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/ether_rx_ctrl.sv
// Turns received words into single-outstanding register bus transactions and
// forwards read responses to the transmit path. Option: ETHER_RX_CTRL_DROP_COUNT_EN.
module ether_rx_ctrl
  import ether_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axiiv,
  input  logic [31:0]           axiid,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rw_o,
  output logic                  valid_o,
  input  logic                  resp_valid_i,
  input  logic [DATA_WIDTH-1:0] resp_data_i,
  output logic                  tx_start_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  input  logic                  tx_busy_i,
  output logic                  busy_o,
`ifdef ETHER_RX_CTRL_DROP_COUNT_EN
  output logic [15:0]           drop_count_o,
`endif
  output logic                  timeout_o
);

  localparam int CW = $clog2(RESP_TIMEOUT) + 1;
  // The timeout is taken when the counter's next value would reach RESP_TIMEOUT-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(RESP_TIMEOUT - 2);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  timeout_q, timeout_d;
  logic                  load;
  logic                  tx_start;
  logic                  word_rw;

  rx_word_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_decode (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .word_i (axiid),
    .rw_o   (word_rw),
    .addr_o (addr_o),
    .data_o (data_o)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    timeout_d = 1'b0;
    load      = 1'b0;
    tx_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (axiiv) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (word_rw) begin
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        // A response arriving on the last allowed cycle still beats the timeout.
        if (resp_valid_i) begin
          tx_data_d = resp_data_i;
          state_d   = TX_REQ;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_REQ: begin
        if (!tx_busy_i) begin
          tx_start = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_data_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ETHER_RX_CTRL_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Acceptance looks only at the current state, so a word arriving while the
  // FSM is on its way back to IDLE is still counted as dropped.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (axiiv && (state_q != IDLE) && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count_o = drop_cnt_q;
`endif

  assign rw_o       = word_rw;
  assign valid_o    = (state_q == ISSUE);
  assign busy_o     = (state_q != IDLE);
  assign tx_start_o = tx_start;
  assign tx_data_o  = tx_data_q;
  assign timeout_o  = timeout_q;

endmodule
